// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcode/funct encodings, ALU operation
// codes, branch/memory/multiply-divide enums, the registered control word
// layout and the HI/LO unit FSM states.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam int ALU_W = 5;
  localparam logic [ALU_W-1:0] ALU_NOP  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_NOR  = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'd9;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'd10;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd11;
  localparam logic [ALU_W-1:0] ALU_LUI  = 5'd12;
  localparam logic [ALU_W-1:0] ALU_MFHI = 5'd13;
  localparam logic [ALU_W-1:0] ALU_MFLO = 5'd14;
  localparam logic [ALU_W-1:0] ALU_SLLV = 5'd15;
  localparam logic [ALU_W-1:0] ALU_SRLV = 5'd16;
  localparam logic [ALU_W-1:0] ALU_SRAV = 5'd17;

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ} br_cond_e;
  typedef enum logic [1:0] {MS_WORD, MS_BYTE_S, MS_BYTE_U} mem_size_e;
  typedef enum logic [1:0] {MD_NONE, MD_MUL, MD_DIV} md_op_e;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             ext_op;
    logic             reg_dst;
    logic             jmp;
    logic             jal;
    br_cond_e         br_cond;
    mem_size_e        mem_size;
    logic [ALU_W-1:0] alu_op;
    logic [4:0]       dest;
    logic [4:0]       rs;
    logic [4:0]       rt;
    md_op_e           md_op;
  } ctl_word_t;

endpackage

// File: rtl/decode_ctl_comb.sv
// Pure combinational instruction decoder.
//   instr    : fetched 32-bit instruction
//   cw       : control word (all-zero for undecodable encodings)
//   illegal  : opcode (or REGIMM rt) not recognised
//   reads_rt : instruction sources the rt register (load-use hazard check)
//   hilo_use : instruction touches the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo)
module decode_ctl_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctl_word_t   cw,
  output logic        illegal,
  output logic        reads_rt,
  output logic        hilo_use
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    cw       = '0;
    illegal  = 1'b0;
    reads_rt = 1'b0;
    hilo_use = 1'b0;
    cw.rs    = rs;
    cw.rt    = rt;
    case (op)
      OP_RTYPE: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
        cw.dest      = rd;
        reads_rt     = 1'b1;
        case (funct)
          F_ADD, F_ADDU:   cw.alu_op = ALU_ADD;
          F_SUB, F_SUBU:   cw.alu_op = ALU_SUB;
          F_AND:           cw.alu_op = ALU_AND;
          F_OR:            cw.alu_op = ALU_OR;
          F_XOR:           cw.alu_op = ALU_XOR;
          F_NOR:           cw.alu_op = ALU_NOR;
          F_SLT:           cw.alu_op = ALU_SLT;
          F_SLTU:          cw.alu_op = ALU_SLTU;
          F_SLL:           cw.alu_op = ALU_SLL;
          F_SRL:           cw.alu_op = ALU_SRL;
          F_SRA:           cw.alu_op = ALU_SRA;
          F_SLLV:          cw.alu_op = ALU_SLLV;
          F_SRLV:          cw.alu_op = ALU_SRLV;
          F_SRAV:          cw.alu_op = ALU_SRAV;
          F_JR:            begin cw.reg_write = 1'b0; reads_rt = 1'b0; end
          F_JALR:          reads_rt = 1'b0;
          F_MFHI:          begin cw.alu_op = ALU_MFHI; reads_rt = 1'b0; hilo_use = 1'b1; end
          F_MFLO:          begin cw.alu_op = ALU_MFLO; reads_rt = 1'b0; hilo_use = 1'b1; end
          F_MTHI, F_MTLO:  begin cw.reg_write = 1'b0; reads_rt = 1'b0; hilo_use = 1'b1; end
          F_MULT, F_MULTU: begin cw.reg_write = 1'b0; cw.md_op = MD_MUL; hilo_use = 1'b1; end
          F_DIV, F_DIVU:   begin cw.reg_write = 1'b0; cw.md_op = MD_DIV; hilo_use = 1'b1; end
          default:         cw.reg_write = 1'b0;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cw.reg_write = 1'b1;
        cw.alu_src   = 1'b1;
        cw.dest      = rt;
        cw.ext_op    = (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU);
        case (op)
          OP_ADDIU: cw.alu_op = ALU_ADD;
          OP_SLTI:  cw.alu_op = ALU_SLT;
          OP_SLTIU: cw.alu_op = ALU_SLTU;
          OP_ANDI:  cw.alu_op = ALU_AND;
          OP_ORI:   cw.alu_op = ALU_OR;
          OP_XORI:  cw.alu_op = ALU_XOR;
          default:  cw.alu_op = ALU_LUI;
        endcase
      end
      OP_LW, OP_LB, OP_LBU: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.alu_src    = 1'b1;
        cw.ext_op     = 1'b1;
        cw.alu_op     = ALU_ADD;
        cw.dest       = rt;
        cw.mem_size   = (op == OP_LW) ? MS_WORD : (op == OP_LB) ? MS_BYTE_S : MS_BYTE_U;
      end
      OP_SW, OP_SB: begin
        cw.mem_write = 1'b1;
        cw.alu_src   = 1'b1;
        cw.ext_op    = 1'b1;
        cw.alu_op    = ALU_ADD;
        cw.mem_size  = (op == OP_SW) ? MS_WORD : MS_BYTE_S;
        reads_rt     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cw.ext_op  = 1'b1;
        cw.alu_op  = ALU_SUB;
        cw.br_cond = (op == OP_BEQ) ? BR_EQ : BR_NE;
        reads_rt   = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        cw.ext_op  = 1'b1;
        cw.br_cond = (op == OP_BLEZ) ? BR_LEZ : BR_GTZ;
      end
      OP_REGIMM: begin
        cw.ext_op = 1'b1;
        case (rt)
          5'd0:    cw.br_cond = BR_LTZ;
          5'd1:    cw.br_cond = BR_GEZ;
          default: illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL: begin
        cw.rs  = '0;
        cw.rt  = '0;
        cw.jmp = 1'b1;
        if (op == OP_JAL) begin
          cw.jal       = 1'b1;
          cw.reg_write = 1'b1;
          cw.dest      = 5'd31;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      cw       = '0;
      reads_rt = 1'b0;
      hilo_use = 1'b0;
    end
    // $0 is never a real destination
    if (cw.dest == 5'd0) cw.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_ctl_stage.sv
// Decode stage: registers the decoded control word with valid/ready
// handshaking, load-use interlock, HI/LO unit occupancy tracking and flush.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/instr/in_ready : instruction input handshake
//   flush                 : kill held word and any presented instruction
//   out_ready/out_valid   : control word output handshake
//   reg_write..md_op      : registered control word fields
//   illegal               : held word came from an undecodable instruction
//   md_busy               : HI/LO unit occupied
module decode_ctl_stage
  import decode_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        instr,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               alu_src,
  output logic               ext_op,
  output logic               reg_dst,
  output logic               jmp,
  output logic               jal,
  output logic [2:0]         br_cond,
  output logic [1:0]         mem_size,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [4:0]         dest,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [1:0]         md_op,
  output logic               illegal,
  output logic               md_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  ctl_word_t  cw, q;
  logic       illegal_c, reads_rt, hilo_use;
  logic       out_valid_q, illegal_q;
  logic       adv, load_stall, md_stall, accept;
  md_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, md_load;

  decode_ctl_comb u_dec (
    .instr    (instr),
    .cw       (cw),
    .illegal  (illegal_c),
    .reads_rt (reads_rt),
    .hilo_use (hilo_use)
  );

  assign adv        = !out_valid_q || out_ready;
  assign load_stall = out_valid_q && q.mem_to_reg && (q.dest != 5'd0) &&
                      ((instr[25:21] == q.dest) || (reads_rt && (instr[20:16] == q.dest)));
  assign md_stall   = (state_q == MD_BUSY) && hilo_use;
  // during flush the presented instruction is swallowed, so it is "taken"
  assign in_ready   = flush || (adv && !load_stall && !md_stall);
  assign accept     = in_valid && in_ready && !flush;
  assign md_load    = (cw.md_op == MD_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // Busy cycles = latency-1: the unit leaves BUSY on the edge where the
  // counter reaches 0, so a dependent op issues exactly LAT cycles later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: if (accept && (cw.md_op != MD_NONE)) begin
        cnt_d = md_load;
        if (md_load != '0) state_d = MD_BUSY;
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stalled or idle cycles load a bubble with a zeroed word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      q           <= '0;
    end else if (adv) begin
      out_valid_q <= accept;
      illegal_q   <= accept && illegal_c;
      q           <= accept ? cw : '0;
    end
  end

  assign out_valid  = out_valid_q;
  assign illegal    = illegal_q;
  assign md_busy    = (state_q == MD_BUSY);
  assign reg_write  = q.reg_write;
  assign mem_to_reg = q.mem_to_reg;
  assign mem_write  = q.mem_write;
  assign alu_src    = q.alu_src;
  assign ext_op     = q.ext_op;
  assign reg_dst    = q.reg_dst;
  assign jmp        = q.jmp;
  assign jal        = q.jal;
  assign br_cond    = q.br_cond;
  assign mem_size   = q.mem_size;
  assign alu_op     = ALUOP_W'(q.alu_op);
  assign dest       = q.dest;
  assign rs         = q.rs;
  assign rt         = q.rt;
  assign md_op      = q.md_op;

endmodule

// File: tb/tb_decode_ctl_stage.sv
module tb_decode_ctl_stage;
  import decode_pkg::*;

  typedef struct packed {
    logic [8:0] f;  // {illegal,reg_write,mem_to_reg,mem_write,alu_src,ext_op,reg_dst,jmp,jal}
    logic [2:0] br;
    logic [1:0] ms;
    logic [4:0] alu, dst, s, t;
    logic [1:0] md;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_ready, out_valid;
  logic [31:0] instr;
  logic reg_write, mem_to_reg, mem_write, alu_src, ext_op, reg_dst, jmp, jal, illegal, md_busy;
  logic [2:0] br_cond;
  logic [1:0] mem_size, md_op;
  logic [4:0] alu_op, dest, rs, rt;

  int n_chk = 0, n_pass = 0, n_out = 0, cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decode_ctl_stage #(.ALUOP_W(5), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .alu_src(alu_src), .ext_op(ext_op), .reg_dst(reg_dst), .jmp(jmp), .jal(jal),
    .br_cond(br_cond), .mem_size(mem_size), .alu_op(alu_op), .dest(dest),
    .rs(rs), .rt(rt), .md_op(md_op), .illegal(illegal), .md_busy(md_busy)
  );

  function automatic exp_t ex(input logic [8:0] f, input logic [2:0] br, input logic [1:0] ms,
                              input logic [4:0] alu, d, s, t, input logic [1:0] md);
    ex = {f, br, ms, alu, d, s, t, md};
  endfunction

  function automatic exp_t got_word();
    got_word = {illegal, reg_write, mem_to_reg, mem_write, alu_src, ext_op, reg_dst, jmp, jal,
                br_cond, mem_size, alu_op, dest, rs, rt, md_op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Scoreboard monitor: every word the EX stage takes is matched in order.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got %h expected none", got_word());
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("ctl_word_%0d", n_out), 64'(got_word()), 64'(e));
      end
      n_out++;
    end
  end

  // Present an instruction until accepted (called #1 after a rising edge).
  task automatic issue(input logic [31:0] ins, input exp_t e, input bit push,
                       output int stalls, output int acc);
    stalls = 0;
    acc    = -1;
    in_valid = 1'b1;
    instr    = ins;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc < 0) chk($sformatf("accept_timeout_%h", ins), 64'(stalls), 64'(0));
  endtask

  logic [31:0] vi [10];
  exp_t        ve [10];
  int st, a1, a2, b0;

  initial begin
    vi[0] = 32'h24220005; ve[0] = ex(9'b010011000, BR_NONE, MS_WORD, ALU_ADD, 5'd2, 5'd1, 5'd2, MD_NONE);
    vi[1] = 32'h34071234; ve[1] = ex(9'b010010000, BR_NONE, MS_WORD, ALU_OR, 5'd7, 5'd0, 5'd7, MD_NONE);
    vi[2] = 32'h3C08ABCD; ve[2] = ex(9'b010010000, BR_NONE, MS_WORD, ALU_LUI, 5'd8, 5'd0, 5'd8, MD_NONE);
    vi[3] = 32'hAC230004; ve[3] = ex(9'b000111000, BR_NONE, MS_WORD, ALU_ADD, 5'd0, 5'd1, 5'd3, MD_NONE);
    vi[4] = 32'h10220003; ve[4] = ex(9'b000001000, BR_EQ, MS_WORD, ALU_SUB, 5'd0, 5'd1, 5'd2, MD_NONE);
    vi[5] = 32'h0C000010; ve[5] = ex(9'b010000011, BR_NONE, MS_WORD, ALU_NOP, 5'd31, 5'd0, 5'd0, MD_NONE);
    vi[6] = 32'h24200001; ve[6] = ex(9'b000011000, BR_NONE, MS_WORD, ALU_ADD, 5'd0, 5'd1, 5'd0, MD_NONE);
    vi[7] = 32'hFC000000; ve[7] = ex(9'b100000000, BR_NONE, MS_WORD, ALU_NOP, 5'd0, 5'd0, 5'd0, MD_NONE);
    vi[8] = 32'h04020000; ve[8] = ex(9'b100000000, BR_NONE, MS_WORD, ALU_NOP, 5'd0, 5'd0, 5'd0, MD_NONE);
    vi[9] = 32'h04210004; ve[9] = ex(9'b000001000, BR_GEZ, MS_WORD, ALU_NOP, 5'd0, 5'd1, 5'd1, MD_NONE);

    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_md_busy", 64'(md_busy), 64'(0));
    chk("reset_word", 64'(got_word()), 64'(0));
    rst = 1'b0;

    // Decode table, back to back
    for (int i = 0; i < 10; i++) begin
      issue(vi[i], ve[i], 1'b1, st, a1);
      if (i == 0) chk("latency_addiu", 64'(out_valid), 64'(1));
      chk($sformatf("no_stall_%0d", i), 64'(st), 64'(0));
    end

    // Load-use: lw $3,0($1) ; addu $4,$3,$5
    issue(32'h8C230000, ex(9'b011011000, BR_NONE, MS_WORD, ALU_ADD, 5'd3, 5'd1, 5'd3, MD_NONE), 1'b1, st, a1);
    issue(32'h00652021, ex(9'b010000100, BR_NONE, MS_WORD, ALU_ADD, 5'd4, 5'd3, 5'd5, MD_NONE), 1'b1, st, a2);
    chk("load_use_stalls", 64'(st), 64'(1));
    chk("load_use_gap", 64'(a2 - a1), 64'(2));

    // div $1,$2 ; mflo $6
    b0 = 0;
    issue(32'h0022001A, ex(9'b000000100, BR_NONE, MS_WORD, ALU_NOP, 5'd0, 5'd1, 5'd2, MD_DIV), 1'b1, st, a1);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (md_busy) b0++;
        end
      end
      issue(32'h00003012, ex(9'b010000100, BR_NONE, MS_WORD, ALU_MFLO, 5'd6, 5'd0, 5'd0, MD_NONE), 1'b1, st, a2);
    join
    chk("div_busy_cycles", 64'(b0), 64'(31));
    chk("mflo_stalls", 64'(st), 64'(31));
    chk("mflo_accept_gap", 64'(a2 - a1), 64'(32));

    // Flush kills held word and presented instruction
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(32'h34091111, ex(9'b0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0), 1'b0, st, a1);
    instr = 32'h380A2222; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_held_valid", 64'(out_valid), 64'(1));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    repeat (3) @(posedge clk); #1;
    chk("flush_no_ghost", 64'(out_valid), 64'(0));
    issue(vi[0], ve[0], 1'b1, st, a1);

    // Reset mid-divide with a held word
    issue(32'h0022001A, ex(9'b000000100, BR_NONE, MS_WORD, ALU_NOP, 5'd0, 5'd1, 5'd2, MD_DIV), 1'b1, st, a1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(vi[1], ve[1], 1'b0, st, a2);
    repeat (a1 + 21 - cyc) @(posedge clk);
    #1;
    chk("busy_before_rst", 64'(md_busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    chk("rst_md_busy", 64'(md_busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    issue(32'h00220018, ex(9'b000000100, BR_NONE, MS_WORD, ALU_NOP, 5'd0, 5'd1, 5'd2, MD_MUL), 1'b1, st, a1);
    chk("mult_after_rst_stalls", 64'(st), 64'(0));
    chk("mult_busy", 64'(md_busy), 64'(1));
    repeat (4) @(posedge clk); #1;
    chk("mult_done", 64'(md_busy), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
